// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and parity selectors
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP1,
        TX_STOP2
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - reloadable bit-period down-counter
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             bit_end_o,
    output logic             bit_end_next_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] reload;

    // Reload on request or at every bit boundary; a divisor of 0 behaves as 1.
    always_comb begin
        reload = (div_i == '0) ? '0 : div_i - DIV_W'(1);
        cnt_d  = (load_i || cnt_q == '0) ? reload : cnt_q - DIV_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // bit_end marks the last cycle of a bit; bit_end_next lets the owner register a
    // flag that lines up with that last cycle.
    assign bit_end_o      = (cnt_q == '0);
    assign bit_end_next_o = (cnt_d == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART frame serialiser driven by the control FSM TXen strobe
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              TXen,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              stop2,
    output logic              tx_o,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_e         state_q;
    logic              txen_q;
    logic [DATA_W-1:0] shift_q;
    logic [IDX_W-1:0]  bit_idx_q;
    logic [DIV_W-1:0]  div_q;
    logic              par_en_q;
    logic              par_bit_q;
    logic              stop2_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;

    logic              accept;
    logic [DIV_W-1:0]  div_sel;
    logic              bit_end;
    logic              bit_end_next;

    assign accept  = TXen && !txen_q && (state_q == TX_IDLE);
    // The shadow divisor is not yet valid in the accept cycle, so load from the port then.
    assign div_sel = accept ? baud_div : div_q;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk_i          (PCLK),
        .rst_i          (PRESET),
        .load_i         (accept),
        .div_i          (div_sel),
        .bit_end_o      (bit_end),
        .bit_end_next_o (bit_end_next)
    );

    // Previous TXen level for rising-edge detection.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            txen_q <= 1'b0;
        end else begin
            txen_q <= TXen;
        end
    end

    // Frame state machine; tx_done is set one edge early so it covers the final stop cycle.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= TX_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            div_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                TX_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (accept) begin
                        shift_q   <= tx_data;
                        div_q     <= baud_div;
                        par_en_q  <= parity_en;
                        par_bit_q <= (parity_odd == PAR_EVEN) ? (^tx_data) : ~(^tx_data);
                        stop2_q   <= stop2;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= TX_START;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= '0;
                        state_q   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == LAST_IDX) begin
                            if (par_en_q) begin
                                tx_q    <= par_bit_q;
                                state_q <= TX_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                done_q  <= !stop2_q && bit_end_next;
                                state_q <= TX_STOP1;
                            end
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end
                end
                TX_PARITY: begin
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        done_q  <= !stop2_q && bit_end_next;
                        state_q <= TX_STOP1;
                    end
                end
                TX_STOP1: begin
                    if (bit_end) begin
                        if (stop2_q) begin
                            done_q  <= bit_end_next;
                            state_q <= TX_STOP2;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= TX_IDLE;
                        end
                    end else begin
                        done_q <= !stop2_q && bit_end_next;
                    end
                end
                TX_STOP2: begin
                    if (bit_end) begin
                        busy_q  <= 1'b0;
                        state_q <= TX_IDLE;
                    end else begin
                        done_q <= bit_end_next;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign tx_o    = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - directed vector bench for uart_tx_engine
module tb_uart_tx_engine;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        TXen = 1'b0;
    logic [7:0]  tx_data = '0;
    logic [15:0] baud_div = '0;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        stop2 = 1'b0;
    logic        tx_o;
    logic        tx_busy;
    logic        tx_done;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_engine #(.DATA_W(8), .DIV_W(16)) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .TXen       (TXen),
        .tx_data    (tx_data),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .tx_o       (tx_o),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        string       name;
        logic [15:0] div;
        logic [7:0]  data;
        logic        pe;
        logic        po;
        logic        s2;
        logic [11:0] bits;  // bit i = line level during bit period i
        int          len;   // cycles from tx_o falling to tx_busy falling
    } vec_t;

    vec_t vecs[7];
    vec_t v_hold;
    vec_t v_rst;

    task automatic check3(input string name, input int k, input logic [2:0] act, input logic [2:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d {tx_o,busy,done} got %b expected %b", name, k, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts at a negedge; ends at the negedge just after tx_busy falls so a following
    // call produces a back-to-back request.
    task automatic run_frame(input vec_t v);
        int  eff;
        logic exp_line;
        eff = (v.div == 16'd0) ? 1 : int'(v.div);
        tx_data    = v.data;
        baud_div   = v.div;
        parity_en  = v.pe;
        parity_odd = v.po;
        stop2      = v.s2;
        TXen       = 1'b1;
        for (int k = 0; k <= v.len; k++) begin
            @(negedge PCLK);
            if (k == 0) begin
                tx_data    = ~v.data;
                baud_div   = v.div + 16'd3;
                parity_en  = ~v.pe;
                parity_odd = ~v.po;
                stop2      = ~v.s2;
            end
            if (k == 1 || k == 5) TXen = 1'b0;
            if (k == 3) TXen = 1'b1;
            if (k < v.len) begin
                exp_line = v.bits[k / eff];
                check3(v.name, k, {tx_o, tx_busy, tx_done}, {exp_line, 1'b1, (k == v.len - 1)});
            end else begin
                check3(v.name, k, {tx_o, tx_busy, tx_done}, 3'b100);
            end
        end
    endtask

    initial begin
        int done_cnt;
        int fall_cnt;
        int rise_cnt;
        int low_cnt;
        logic prev_busy;

        vecs[0] = '{"a5_div4",       16'd4, 8'hA5, 1'b0, 1'b0, 1'b0, 12'b0011_0100_1010, 40};
        vecs[1] = '{"a5_div2_even",  16'd2, 8'hA5, 1'b1, 1'b0, 1'b0, 12'b0101_0100_1010, 22};
        vecs[2] = '{"a5_div2_odd",   16'd2, 8'hA5, 1'b1, 1'b1, 1'b0, 12'b0111_0100_1010, 22};
        vecs[3] = '{"00_div3_stop2", 16'd3, 8'h00, 1'b0, 1'b0, 1'b1, 12'b0110_0000_0000, 33};
        vecs[4] = '{"ff_div0",       16'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 12'b0011_1111_1110, 10};
        vecs[5] = '{"01_div1_par_s2",16'd1, 8'h01, 1'b1, 1'b0, 1'b1, 12'b1110_0000_0010, 12};
        vecs[6] = '{"3c_div5_odd",   16'd5, 8'h3C, 1'b1, 1'b1, 1'b0, 12'b0110_0111_1000, 55};
        v_hold  = '{"5a_div1",       16'd1, 8'h5A, 1'b0, 1'b0, 1'b0, 12'b0010_1011_0100, 10};
        v_rst   = '{"55_div4_clean", 16'd4, 8'h55, 1'b0, 1'b0, 1'b0, 12'b0010_1010_1010, 40};

        @(negedge PCLK);
        check3("reset_state", 0, {tx_o, tx_busy, tx_done}, 3'b100);
        PRESET = 1'b0;
        @(negedge PCLK);
        check3("idle_after_reset", 0, {tx_o, tx_busy, tx_done}, 3'b100);

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i]);
        end

        // TXen held high for 100 cycles: exactly one frame.
        repeat (2) @(negedge PCLK);
        tx_data = v_hold.data; baud_div = v_hold.div;
        parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        TXen = 1'b1;
        done_cnt = 0; fall_cnt = 0; rise_cnt = 0;
        prev_busy = tx_busy;
        for (int c = 0; c < 100; c++) begin
            @(negedge PCLK);
            if (tx_done) done_cnt++;
            if (prev_busy && !tx_busy) fall_cnt++;
            if (!prev_busy && tx_busy) rise_cnt++;
            prev_busy = tx_busy;
        end
        check_int("hold_done_pulses", done_cnt, 1);
        check_int("hold_busy_rises", rise_cnt, 1);
        check_int("hold_busy_falls", fall_cnt, 1);
        TXen = 1'b0;
        @(negedge PCLK);
        run_frame(v_hold);

        // Reset in the middle of a data bit.
        repeat (2) @(negedge PCLK);
        tx_data = 8'h55; baud_div = 16'd4;
        parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        TXen = 1'b1;
        repeat (10) @(negedge PCLK);
        PRESET = 1'b1;
        TXen = 1'b0;
        #1;
        check3("async_reset", 0, {tx_o, tx_busy, tx_done}, 3'b100);
        @(negedge PCLK);
        PRESET = 1'b0;
        done_cnt = 0; low_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge PCLK);
            if (tx_done) done_cnt++;
            if (!tx_o || tx_busy) low_cnt++;
        end
        check_int("no_done_after_reset", done_cnt, 0);
        check_int("line_idle_after_reset", low_cnt, 0);
        run_frame(v_rst);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
